dmem_wait_responder: RTL and testbench

Data-memory responder for the RISC-V core's load/store port. It replaces the zero-latency combinational data memory with a valid/ready request/response interface, programmable wait states and byte-lane writes. One transaction is outstanding at a time. This block lets the multicycle and pipelined cores be exercised against a memory with realistic latency.

---
 rtl/dmem_pkg.sv | 20 ++
 rtl/dmem_bytelane_ram.sv | 28 ++
 rtl/dmem_wait_responder.sv | 126 ++++++++++++
 tb/tb_dmem_wait_responder.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types and widths for the wait-state data-memory responder
package dmem_pkg;

  localparam int WORD_W = 32;
  localparam int BE_W   = 4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } dmem_state_t;

  typedef struct packed {
    logic              we;
    logic [WORD_W-1:0] addr;
    logic [WORD_W-1:0] wdata;
    logic [BE_W-1:0]   be;
  } dmem_req_t;

endpackage

// File: rtl/dmem_bytelane_ram.sv
// rtl/dmem_bytelane_ram.sv - word-wide RAM with per-byte write enables and combinational read
module dmem_bytelane_ram
  import dmem_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [AW-1:0]     i_idx,
  input  logic [WORD_W-1:0] i_wdata,
  input  logic [BE_W-1:0]   i_be,
  output logic [WORD_W-1:0] o_rdata
);

  logic [WORD_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int i = 0; i < BE_W; i++) begin
        if (i_be[i]) r_mem[i_idx][8*i +: 8] <= i_wdata[8*i +: 8];
      end
    end
  end

  assign o_rdata = r_mem[i_idx];

endmodule

// File: rtl/dmem_wait_responder.sv
// rtl/dmem_wait_responder.sv - valid/ready data memory with programmable wait states
// One transaction in flight; the memory access happens on the edge that enters RESP.
module dmem_wait_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2,
  parameter int WAIT_W  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [WORD_W-1:0] req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  input  logic [BE_W-1:0]   req_be,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [WORD_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  dmem_state_t       r_state;
  dmem_req_t         r_req;
  logic [WAIT_W-1:0] r_cnt;
  logic              r_rsp_valid;
  logic [WORD_W-1:0] r_rsp_rdata;
  logic              r_rsp_err;

  dmem_req_t         w_acc;
  logic              w_accept;
  logic              w_err;
  logic              w_enter_resp;
  logic              w_ram_we;
  logic [WORD_W-1:0] w_ram_rdata;
  logic [WORD_W-1:0] w_rsp_rdata;

  assign req_ready = (r_state == IDLE) & ~reset;
  assign w_accept  = req_valid & req_ready;

  // With LATENCY==1 the access happens on the accept edge, so use the live request.
  always_comb begin
    w_acc = r_req;
    if (r_state == IDLE) begin
      w_acc.we    = req_we;
      w_acc.addr  = req_addr;
      w_acc.wdata = req_wdata;
      w_acc.be    = req_be;
    end
  end

  assign w_err = (w_acc.addr[1:0] != 2'b00) ||
                 ({2'b00, w_acc.addr[WORD_W-1:2]} >= 32'(DEPTH));

  assign w_enter_resp = ((r_state == IDLE) && w_accept && (LATENCY == 1)) ||
                        ((r_state == WAIT) && (r_cnt == WAIT_W'(1)));

  assign w_ram_we    = w_enter_resp & w_acc.we & ~w_err & ~reset;
  assign w_rsp_rdata = (w_acc.we | w_err) ? '0 : w_ram_rdata;

  dmem_bytelane_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_ram_we),
    .i_idx   (w_acc.addr[AW+1:2]),
    .i_wdata (w_acc.wdata),
    .i_be    (w_acc.be),
    .o_rdata (w_ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_req       <= '0;
      r_cnt       <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_req <= w_acc;
            if (LATENCY == 1) begin
              r_state     <= RESP;
              r_rsp_valid <= 1'b1;
              r_rsp_rdata <= w_rsp_rdata;
              r_rsp_err   <= w_err;
            end else begin
              r_state <= WAIT;
              r_cnt   <= WAIT_W'(LATENCY - 1);
            end
          end
        end
        WAIT: begin
          r_cnt <= r_cnt - WAIT_W'(1);
          if (w_enter_resp) begin
            r_state     <= RESP;
            r_rsp_valid <= 1'b1;
            r_rsp_rdata <= w_rsp_rdata;
            r_rsp_err   <= w_err;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            r_state     <= IDLE;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_dmem_wait_responder.sv
// tb/tb_dmem_wait_responder.sv - directed bench for dmem_wait_responder
// Instances 0/1/2 run with LATENCY 2/4/1 and share clock and reset.
module tb_dmem_wait_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid [3];
  logic        req_ready [3];
  logic        req_we    [3];
  logic [31:0] req_addr  [3];
  logic [31:0] req_wdata [3];
  logic [3:0]  req_be    [3];
  logic        rsp_valid [3];
  logic        rsp_ready [3];
  logic [31:0] rsp_rdata [3];
  logic        rsp_err   [3];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    dmem_wait_responder #(
      .DEPTH   (256),
      .LATENCY ((g == 0) ? 2 : (g == 1) ? 4 : 1),
      .WAIT_W  (4)
    ) u_dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid[g]),
      .req_ready (req_ready[g]),
      .req_we    (req_we[g]),
      .req_addr  (req_addr[g]),
      .req_wdata (req_wdata[g]),
      .req_be    (req_be[g]),
      .rsp_valid (rsp_valid[g]),
      .rsp_ready (rsp_ready[g]),
      .rsp_rdata (rsp_rdata[g]),
      .rsp_err   (rsp_err[g])
    );
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Full transaction from a negedge; holds rsp_ready low for `hold` cycles in RESP.
  task automatic txn(input int k, input logic we, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [3:0] be, input int lat,
                     input int hold, output logic [31:0] rdata, output logic err);
    int n;
    logic stable;
    req_valid[k] = 1'b1;
    req_we[k]    = we;
    req_addr[k]  = addr;
    req_wdata[k] = wdata;
    req_be[k]    = be;
    check("ready_before_accept", 32'(req_ready[k]), 32'd1);
    @(negedge clk);
    req_valid[k] = 1'b0;
    check("ready_low_busy", 32'(req_ready[k]), 32'd0);
    n = 1;
    while (!rsp_valid[k] && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("latency", 32'(n), 32'(lat));
    rdata  = rsp_rdata[k];
    err    = rsp_err[k];
    stable = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (!rsp_valid[k] || rsp_rdata[k] !== rdata || rsp_err[k] !== err || req_ready[k])
        stable = 1'b0;
    end
    if (hold > 0) check("backpressure_stable", 32'(stable), 32'd1);
    rsp_ready[k] = 1'b1;
    @(negedge clk);
    rsp_ready[k] = 1'b0;
    check("valid_cleared", 32'(rsp_valid[k]), 32'd0);
    check("ready_after_hs", 32'(req_ready[k]), 32'd1);
  endtask

  logic [31:0] rd;
  logic        er;
  logic        quiet;
  int          acc_edge [2];
  int          n_acc;
  logic        pend;
  logic [7:0]  vmask;
  logic [31:0] seen [2];
  int          n_seen;

  initial begin
    for (int k = 0; k < 3; k++) begin
      req_valid[k] = 1'b0; req_we[k] = 1'b0; req_addr[k] = '0;
      req_wdata[k] = '0;   req_be[k] = 4'h0; rsp_ready[k] = 1'b0;
    end
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_req_ready", 32'(req_ready[0]), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid[0]), 32'd0);
    check("rst_rsp_rdata", rsp_rdata[0], 32'd0);
    check("rst_rsp_err", 32'(rsp_err[0]), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Instance 0, LATENCY=2
    txn(0, 1'b1, 32'h14, 32'hDEADBEEF, 4'hF, 2, 0, rd, er);
    check("store_rdata_zero", rd, 32'd0);
    check("store_err", 32'(er), 32'd0);
    txn(0, 1'b0, 32'h14, 32'h0, 4'h0, 2, 0, rd, er);
    check("load_deadbeef", rd, 32'hDEADBEEF);
    check("load_err", 32'(er), 32'd0);

    txn(0, 1'b1, 32'h20, 32'h11223344, 4'hF, 2, 0, rd, er);
    txn(0, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 2, 0, rd, er);
    txn(0, 1'b0, 32'h20, 32'h0, 4'h0, 2, 0, rd, er);
    check("bytelane_merge", rd, 32'h11BB33DD);
    txn(0, 1'b1, 32'h20, 32'hFFFFFFFF, 4'h0, 2, 0, rd, er);
    check("be0_err", 32'(er), 32'd0);
    txn(0, 1'b0, 32'h20, 32'h0, 4'hF, 2, 0, rd, er);
    check("be0_no_change", rd, 32'h11BB33DD);

    txn(0, 1'b0, 32'h14, 32'h0, 4'h0, 2, 5, rd, er);
    check("bp_rdata", rd, 32'hDEADBEEF);

    txn(0, 1'b1, 32'h22, 32'hCAFEF00D, 4'hF, 2, 0, rd, er);
    check("misalign_err", 32'(er), 32'd1);
    check("misalign_rdata", rd, 32'd0);
    txn(0, 1'b0, 32'h20, 32'h0, 4'h0, 2, 0, rd, er);
    check("misalign_unchanged", rd, 32'h11BB33DD);
    txn(0, 1'b1, 32'h0, 32'h01020304, 4'hF, 2, 0, rd, er);
    txn(0, 1'b1, 32'h400, 32'h99999999, 4'hF, 2, 0, rd, er);
    check("oor_store_err", 32'(er), 32'd1);
    txn(0, 1'b0, 32'h400, 32'h0, 4'h0, 2, 0, rd, er);
    check("oor_load_err", 32'(er), 32'd1);
    check("oor_load_rdata", rd, 32'd0);
    txn(0, 1'b0, 32'h0, 32'h0, 4'h0, 2, 0, rd, er);
    check("oor_no_alias", rd, 32'h01020304);

    // Instance 1, LATENCY=4: reset while in WAIT drops the store
    txn(1, 1'b1, 32'h64, 32'h000000AA, 4'hF, 4, 0, rd, er);
    req_valid[1] = 1'b1; req_we[1] = 1'b1; req_addr[1] = 32'h64;
    req_wdata[1] = 32'h55; req_be[1] = 4'hF;
    @(negedge clk);
    req_valid[1] = 1'b0;
    reset = 1'b1;
    quiet = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (rsp_valid[1]) quiet = 1'b0;
    end
    reset = 1'b0;
    @(negedge clk);
    check("ready_after_reset", 32'(req_ready[1]), 32'd1);
    for (int i = 0; i < 5; i++) begin
      if (rsp_valid[1]) quiet = 1'b0;
      @(negedge clk);
    end
    check("no_rsp_after_reset", 32'(quiet), 32'd1);
    txn(1, 1'b0, 32'h64, 32'h0, 4'h0, 4, 0, rd, er);
    check("dropped_store", rd, 32'h000000AA);

    // Instance 2, LATENCY=1: back-to-back loads with valid and rsp_ready held high
    txn(2, 1'b1, 32'h8, 32'h0BADC0DE, 4'hF, 1, 0, rd, er);
    txn(2, 1'b1, 32'hC, 32'h5EED1234, 4'hF, 1, 0, rd, er);
    req_valid[2] = 1'b1; req_we[2] = 1'b0; req_addr[2] = 32'h8; rsp_ready[2] = 1'b1;
    n_acc = 0; n_seen = 0; vmask = '0;
    for (int c = 0; c < 8; c++) begin
      pend = req_valid[2] && req_ready[2];
      if (pend && n_acc < 2) begin acc_edge[n_acc] = c; n_acc++; end
      if (rsp_valid[2]) begin
        vmask[c] = 1'b1;
        if (n_seen < 2) seen[n_seen] = rsp_rdata[2];
        n_seen++;
      end
      @(negedge clk);
      if (pend && n_acc == 1) req_addr[2] = 32'hC;
      if (pend && n_acc == 2) req_valid[2] = 1'b0;
    end
    rsp_ready[2] = 1'b0;
    check("b2b_accepts", 32'(n_acc), 32'd2);
    check("b2b_spacing", 32'(acc_edge[1] - acc_edge[0]), 32'd2);
    check("b2b_valid_pattern", 32'(vmask), 32'b0000_1010);
    check("b2b_rdata0", seen[0], 32'h0BADC0DE);
    check("b2b_rdata1", seen[1], 32'h5EED1234);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
